dither_engine: RTL and testbench
================================

DITHER_ENGINE -- requirements
Module: dither_engine

Interface
REQ-001 SHALL have parameter PIXELS, default 4, meaning pixels per beat (>=1).
REQ-002 SHALL have parameter IN_BITS, default 8, meaning input bits per pixel.
REQ-003 SHALL have parameter OUT_BITS, default 4, meaning output bits per pixel (< IN_BITS); SHIFT = IN_BITS-OUT_BITS.
REQ-004 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  beat qualifier.
REQ-007 SHALL have port in_sof  input  1  first beat of frame; valid only with in_valid; implies in_sol.
REQ-008 SHALL have port in_sol  input  1  first beat of line; valid only with in_valid.
REQ-009 SHALL have port in_data  input  PIXELS*IN_BITS  pixels; pixel 0 in the MSBs, leftmost on screen.
REQ-010 SHALL have port mode  input  2  0 = passthrough/truncate, 1 = ordered 4x4 Bayer, 2 = 1-D error diffusion, 3 = force zero.
REQ-011 SHALL have port out_valid  output  1  output beat qualifier.
REQ-012 SHALL have port out_sol  output  1  delayed in_sol (in_sol OR in_sof).
REQ-013 SHALL have port out_data  output  PIXELS*OUT_BITS  quantised pixels, same ordering as in_data.

Function
REQ-014 SHALL have a fixed latency of 2 cycles: stage 1 registers in_data/flags/positions, stage 2 computes and registers outputs; out_valid = in_valid delayed by 2 cycles.
REQ-015 SHALL have no backpressure; every accepted beat produces exactly one output beat.
REQ-016 SHALL keep a line counter y: 0 on in_sof beat, +1 on in_sol-only beat, wraps modulo 2^16.
REQ-017 SHALL keep a beat counter bx: 0 on in_sol beat, +1 per other valid beat; pixel k has x = bx*PIXELS+k.
REQ-018 SHALL capture mode into an active-mode register only on an in_sof beat; mid-frame changes of mode SHALL be ignored.
REQ-019 Mode 0 SHALL output in>>SHIFT per pixel.
REQ-020 Mode 1 SHALL output min(2^OUT_BITS-1, (in + ((B[y%4][x%4] << SHIFT) >> 4)) >> SHIFT), with B rows {0,8,2,10},{12,4,14,6},{3,11,1,9},{15,7,13,5}.
REQ-021 Mode 2 SHALL process pixels 0..PIXELS-1 in sequence: v = min(in+err, 2^IN_BITS-1); q = v>>SHIFT; err = v - (q<<SHIFT) (unsigned, SHIFT bits) passed to the next pixel.
REQ-022 Mode 2 SHALL carry err from the last pixel of a beat to pixel 0 of the next valid beat of the same line.
REQ-023 Mode 2 err SHALL be cleared to 0 on any in_sol/in_sof beat, before that beat's pixel 0 is processed.
REQ-024 Mode 2 err SHALL be held unchanged across cycles with in_valid low.
REQ-025 Mode 3 SHALL output all zeros with normal valid timing.
REQ-026 Arithmetic SHALL use IN_BITS+1-bit intermediate sums; no wrap-around is permitted, only saturation.

Reset
REQ-027 On rst, out_valid, out_sol, out_data, stage-1 registers, y, bx and err SHALL clear to 0, and the active mode SHALL reset to 0.
REQ-028 A beat in flight when rst asserts SHALL be discarded; after release, output begins only from new input beats.

Structure
REQ-029 Mode encodings and the Bayer matrix SHALL live in a shared package dither_pkg.
REQ-030 Per-pixel add/saturate/shift SHALL be a sub-module dither_quant, instantiated PIXELS times for modes 1 and 2.

Verification (PIXELS=4, IN_BITS=8, OUT_BITS=4)
REQ-031 Mode 0 with beat {0x00,0x7F,0x80,0xFF} SHALL give {0,7,8,F} two cycles later with out_valid=1.
REQ-032 Mode 1 with flat 0x08 SHALL give {0,1,0,1} on line 0 and {1,0,1,0} on line 1; flat 0xFF at y=3, x=0 SHALL saturate to F.
REQ-033 Mode 2 with flat 0x05, two beats in one line, SHALL give {0,0,0,1} then {0,0,1,0}; a new in_sol beat SHALL restart at {0,0,0,1}.
REQ-034 Mode 2 with a 3-cycle in_valid gap between beats SHALL give the same outputs as without the gap, with out_valid low for 3 cycles.
REQ-035 Changing mode 1->0 mid-frame SHALL have no effect until the next in_sof beat, whose output SHALL then follow mode 0.
REQ-036 Asserting rst during a mode 2 line SHALL zero all outputs asynchronously; the first beat after release SHALL give {0,0,0,1} for flat 0x05.

Source files
------------

// File: rtl/dither_pkg.sv
// rtl/dither_pkg.sv - shared mode encodings and 4x4 Bayer threshold table
// Contents: mode_e (2-bit dither mode), LINE_BITS (line/beat counter width),
//           bayer4(row, col) -> 4-bit ordered-dither threshold.
package dither_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BAYER = 2'd1,
    MODE_DIFF  = 2'd2,
    MODE_ZERO  = 2'd3
  } mode_e;

  localparam int LINE_BITS = 16;

  // Row 0 occupies the top nibbles: {0,8,2,10},{12,4,14,6},{3,11,1,9},{15,7,13,5}
  localparam logic [63:0] BAYER_TABLE = 64'h082A_C4E6_3B19_F7D5;

  function automatic logic [3:0] bayer4(input logic [1:0] row, input logic [1:0] col);
    int idx;
    idx = int'({row, col});
    return BAYER_TABLE[63 - 4*idx -: 4];
  endfunction

endpackage

// File: rtl/dither_if.sv
// rtl/dither_if.sv - pixel beat bus between a video source and dither_engine
// Signals: in_valid/in_sof/in_sol/in_data/mode (source -> engine),
//          out_valid/out_sol/out_data (engine -> sink).
// Modports: master = source/sink side, slave = engine side.
interface dither_if #(
  parameter int PIXELS   = 4,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4
);
  logic                         in_valid;
  logic                         in_sof;
  logic                         in_sol;
  logic [PIXELS*IN_BITS-1:0]    in_data;
  logic [1:0]                   mode;
  logic                         out_valid;
  logic                         out_sol;
  logic [PIXELS*OUT_BITS-1:0]   out_data;

  modport master (
    output in_valid, in_sof, in_sol, in_data, mode,
    input  out_valid, out_sol, out_data
  );

  modport slave (
    input  in_valid, in_sof, in_sol, in_data, mode,
    output out_valid, out_sol, out_data
  );
endinterface

// File: rtl/dither_quant.sv
// rtl/dither_quant.sv - one pixel: add offset, saturate, split into quantised value and remainder
// Ports: pix (IN_BITS) input pixel, addend (SHIFT bits) Bayer offset or carried error,
//        q (OUT_BITS) quantised pixel, rem (SHIFT bits) bits dropped by quantisation.
module dither_quant #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4
) (
  input  logic [IN_BITS-1:0]          pix,
  input  logic [IN_BITS-OUT_BITS-1:0] addend,
  output logic [OUT_BITS-1:0]         q,
  output logic [IN_BITS-OUT_BITS-1:0] rem
);
  localparam int SHIFT = IN_BITS - OUT_BITS;

  logic [IN_BITS:0]   sum;
  logic [IN_BITS-1:0] v;

  // One extra bit holds the carry so overflow saturates instead of wrapping.
  assign sum = {1'b0, pix} + (IN_BITS+1)'(addend);
  assign v   = sum[IN_BITS] ? {IN_BITS{1'b1}} : sum[IN_BITS-1:0];
  assign q   = v[IN_BITS-1:SHIFT];
  assign rem = v[SHIFT-1:0];
endmodule

// File: rtl/dither_engine.sv
// rtl/dither_engine.sv - 2-stage pixel quantiser: truncate, ordered Bayer, 1-D error diffusion, zero
// Ports: clk (rising edge), rst (async, active-high), bus (dither_if.slave):
//        in_valid/in_sof/in_sol/in_data/mode in, out_valid/out_sol/out_data out,
//        output appears exactly 2 cycles after the input beat.
module dither_engine
  import dither_pkg::*;
#(
  parameter int PIXELS   = 4,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 4
) (
  input  logic     clk,
  input  logic     rst,
  dither_if.slave  bus
);
  localparam int SHIFT = IN_BITS - OUT_BITS;
  localparam int IW    = PIXELS * IN_BITS;
  localparam int OW    = PIXELS * OUT_BITS;
  // Only x mod 4 matters for the Bayer lookup, so PIXELS is reduced mod 4 too.
  localparam logic [1:0] P_LO = 2'(PIXELS % 4);

  // ---------------- stage 1: positions, flags, mode ----------------
  logic [LINE_BITS-1:0] y_q, bx_q, y_cur, bx_cur;
  logic                 line_start;
  mode_e                act_mode, beat_mode;

  logic          s1_valid, s1_sol;
  logic [IW-1:0] s1_data;
  logic [1:0]    s1_y, s1_bx;
  mode_e         s1_mode;

  assign line_start = bus.in_sol | bus.in_sof;

  always_comb begin
    y_cur     = bus.in_sof ? '0 : (bus.in_sol ? y_q + 16'd1 : y_q);
    bx_cur    = line_start ? '0 : bx_q + 16'd1;
    // The frame's first beat already uses the newly captured mode.
    beat_mode = bus.in_sof ? mode_e'(bus.mode) : act_mode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      bx_q     <= '0;
      act_mode <= MODE_PASS;
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_data  <= '0;
      s1_y     <= '0;
      s1_bx    <= '0;
      s1_mode  <= MODE_PASS;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        y_q      <= y_cur;
        bx_q     <= bx_cur;
        act_mode <= beat_mode;
        s1_sol   <= line_start;
        s1_data  <= bus.in_data;
        s1_y     <= y_cur[1:0];
        s1_bx    <= bx_cur[1:0];
        s1_mode  <= beat_mode;
      end
    end
  end

  // ---------------- stage 2: per-pixel quantisation ----------------
  logic [SHIFT-1:0]             err_q;
  logic [PIXELS:0][SHIFT-1:0]   err_chain;
  logic [OW-1:0]                q_data;
  logic                         out_valid_q, out_sol_q;
  logic [OW-1:0]                out_data_q;

  // Error restarts at each line so diffusion never leaks across lines.
  assign err_chain[0] = s1_sol ? '0 : err_q;

  for (genvar k = 0; k < PIXELS; k++) begin : g_pix
    logic [IN_BITS-1:0]  pix;
    logic [1:0]          x2;
    logic [3:0]          thr;
    logic [SHIFT-1:0]    bayer_add;
    logic [SHIFT-1:0]    addend;
    logic [OUT_BITS-1:0] qv;
    logic [SHIFT-1:0]    rem;

    assign pix       = s1_data[(PIXELS-1-k)*IN_BITS +: IN_BITS];
    assign x2        = s1_bx * P_LO + 2'(k % 4);
    assign thr       = bayer4(s1_y, x2);
    // Threshold scaled to the dropped-bit range: (B << SHIFT) >> 4.
    assign bayer_add = SHIFT'({thr, {SHIFT{1'b0}}} >> 4);
    assign addend    = (s1_mode == MODE_BAYER) ? bayer_add : err_chain[k];

    dither_quant #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_quant (
      .pix    (pix),
      .addend (addend),
      .q      (qv),
      .rem    (rem)
    );

    assign err_chain[k+1] = rem;
    assign q_data[(PIXELS-1-k)*OUT_BITS +: OUT_BITS] =
        (s1_mode == MODE_PASS) ? pix[IN_BITS-1:SHIFT] :
        (s1_mode == MODE_ZERO) ? '0 : qv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sol_q   <= 1'b0;
      out_data_q  <= '0;
      err_q       <= '0;
    end else begin
      out_valid_q <= s1_valid;
      out_sol_q   <= s1_valid & s1_sol;
      // Idle cycles leave both the output word and the carried error untouched.
      if (s1_valid) begin
        out_data_q <= q_data;
        err_q      <= (s1_mode == MODE_DIFF) ? err_chain[PIXELS] : '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sol   = out_sol_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_dither_engine.sv
// tb/tb_dither_engine.sv - directed self-checking bench for dither_engine (4 px, 8 -> 4 bits)
module tb_dither_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dither_if #(.PIXELS(4), .IN_BITS(8), .OUT_BITS(4)) bus ();

  dither_engine #(.PIXELS(4), .IN_BITS(8), .OUT_BITS(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected-result pipeline: [0] = beat driven one cycle ago, [1] = two cycles ago.
  bit          p_chk [2];
  bit          p_val [2];
  bit          p_sol [2];
  logic [15:0] p_dat [2];
  string       p_tag [2];

  task automatic cycle(input bit v, input bit sof, input bit sol, input logic [31:0] d,
                       input logic [1:0] m, input logic [15:0] e, input string tag);
    @(negedge clk);
    if (p_chk[1]) begin
      check_eq({p_tag[1], "_valid"}, 32'(bus.out_valid), 32'(p_val[1]));
      check_eq({p_tag[1], "_sol"}, 32'(bus.out_sol), 32'(p_sol[1]));
      if (p_val[1]) check_eq({p_tag[1], "_data"}, 32'(bus.out_data), 32'(p_dat[1]));
    end
    p_chk[1] = p_chk[0];  p_val[1] = p_val[0];  p_sol[1] = p_sol[0];
    p_dat[1] = p_dat[0];  p_tag[1] = p_tag[0];
    p_chk[0] = 1'b1;      p_val[0] = v;         p_sol[0] = v & (sol | sof);
    p_dat[0] = e;         p_tag[0] = tag;
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_sol   = sol;
    bus.in_data  = d;
    bus.mode     = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 16'h0, "idle");
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_sol   = 1'b0;
    bus.in_data  = '0;
    bus.mode     = 2'd0;
    p_chk[0] = 1'b0;
    p_chk[1] = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("reset_valid", 32'(bus.out_valid), 32'h0);
    check_eq("reset_sol", 32'(bus.out_sol), 32'h0);
    check_eq("reset_data", 32'(bus.out_data), 32'h0);
    rst = 1'b0;

    // Mode 0 truncation
    cycle(1, 1, 1, 32'h007F80FF, 2'd0, 16'h078F, "m0");
    idle(2);

    // Mode 1 ordered dither, lines 0..3, saturation at y=3
    cycle(1, 1, 1, 32'h08080808, 2'd1, 16'h0101, "m1_y0");
    cycle(1, 0, 1, 32'h08080808, 2'd1, 16'h1010, "m1_y1");
    cycle(1, 0, 1, 32'h08080808, 2'd1, 16'h0101, "m1_y2");
    cycle(1, 0, 1, 32'hFFFFFFFF, 2'd1, 16'hFFFF, "m1_sat");

    // Mode 2 error diffusion with carry, 3-cycle gap and line restart
    cycle(1, 1, 1, 32'h05050505, 2'd2, 16'h0001, "m2_b0");
    cycle(1, 0, 0, 32'h05050505, 2'd2, 16'h0010, "m2_b1");
    idle(3);
    cycle(1, 0, 0, 32'h05050505, 2'd2, 16'h0100, "m2_b2");
    cycle(1, 0, 1, 32'h05050505, 2'd2, 16'h0001, "m2_sol");
    cycle(1, 0, 0, 32'h05050505, 2'd2, 16'h0010, "m2_sol_b1");

    // Mid-frame mode change ignored until the next frame start
    cycle(1, 1, 1, 32'h08080808, 2'd1, 16'h0101, "mf_sof1");
    cycle(1, 0, 0, 32'h08080808, 2'd0, 16'h0101, "mf_mid");
    cycle(1, 1, 1, 32'h80808080, 2'd0, 16'h8888, "mf_sof0");

    // Mode 3 forces zero, mode input still ignored mid-frame
    cycle(1, 1, 1, 32'hFFFFFFFF, 2'd3, 16'h0000, "m3");
    cycle(1, 0, 1, 32'h12345678, 2'd0, 16'h0000, "m3_sol");

    // Reset in the middle of a mode 2 line
    cycle(1, 1, 1, 32'h05050505, 2'd2, 16'h0001, "rst_b0");
    cycle(1, 0, 0, 32'h05050505, 2'd2, 16'h0010, "rst_b1");
    cycle(0, 0, 0, 32'h0, 2'd0, 16'h0, "idle");
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_async_sol", 32'(bus.out_sol), 32'h0);
    check_eq("rst_async_data", 32'(bus.out_data), 32'h0);
    p_chk[0] = 1'b0;
    p_chk[1] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_hold_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;
    cycle(1, 1, 1, 32'h05050505, 2'd2, 16'h0001, "post_rst");
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
